// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: issue, forwarding, flush and multiplier sequencing for the D/E/M pipeline
module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_codop,
    input  logic [3:0]       in_rs1,
    input  logic [3:0]       in_rs2,
    input  logic [3:0]       in_rd,
    input  logic             br_taken,
    output logic [1:0]       fwd1,
    output logic [1:0]       fwd2,
    output logic [1:0]       fwd3,
    output logic             d_valid,
    output logic             e_valid,
    output logic             m_valid,
    output logic             pc_redirect,
    output logic             mult_start,
    output logic             mult_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_st_e;

    localparam logic [3:0] OP_JMP  = 4'b1011;
    localparam logic [3:0] OP_BNQ  = 4'b1100;
    localparam logic [3:0] OP_MFLO = 4'b1101;
    localparam logic [3:0] OP_MFHI = 4'b1110;
    localparam logic [3:0] OP_MULT = 4'b1111;
    localparam logic [7:0] CNT_INIT = 8'(MULT_LAT - 1);

    function automatic logic writes_rd(input logic [3:0] op);
        return op <= 4'd10 || op == OP_MFLO || op == OP_MFHI;
    endfunction

    function automatic logic reads_rs1(input logic [3:0] op);
        return op <= 4'd5 || op == OP_MULT;
    endfunction

    function automatic logic reads_rs2(input logic [3:0] op);
        return op <= 4'd10 || op == OP_MULT;
    endfunction

    logic             d_valid_q, d_valid_d, e_valid_q, e_valid_d, m_valid_q, m_valid_d;
    logic [3:0]       d_op_q, d_op_d, e_op_q, e_op_d;
    logic [3:0]       d_rd_q, d_rd_d, e_rd_q, e_rd_d, m_rd_q, m_rd_d;
    logic             m_wr_q, m_wr_d;
    mult_st_e         st_q, st_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             d_wr, e_wr, raw, mult_op, struct_hz, issue;

    // Hazard detection, forwarding selects and next-state for all stage shadows and counters
    always_comb begin
        d_wr        = d_valid_q & writes_rd(d_op_q);
        e_wr        = e_valid_q & writes_rd(e_op_q);
        pc_redirect = e_valid_q & (e_op_q == OP_JMP | (e_op_q == OP_BNQ & br_taken));
        raw         = d_wr & ((reads_rs1(in_codop) & d_rd_q == in_rs1) |
                              (reads_rs2(in_codop) & d_rd_q == in_rs2));
        mult_start  = d_valid_q & d_op_q == OP_MULT & ~pc_redirect;
        mult_busy   = st_q == BUSY | mult_start;
        mult_op     = in_codop == OP_MULT | in_codop == OP_MFLO | in_codop == OP_MFHI;
        struct_hz   = mult_op & (mult_busy | (d_valid_q & d_op_q == OP_MULT));
        in_ready    = ~(raw | struct_hz | pc_redirect);
        issue       = in_valid & in_ready;
        fwd1 = (e_wr & e_rd_q == in_rs1) ? 2'b01 : (m_wr_q & m_rd_q == in_rs1) ? 2'b10 : 2'b00;
        fwd2 = (e_wr & e_rd_q == in_rs2) ? 2'b01 : (m_wr_q & m_rd_q == in_rs2) ? 2'b10 : 2'b00;
        fwd3 = (e_wr & e_rd_q == in_rd)  ? 2'b01 : (m_wr_q & m_rd_q == in_rd)  ? 2'b10 : 2'b00;
        d_valid_d = issue;
        d_op_d    = issue ? in_codop : 4'b0;
        d_rd_d    = issue ? in_rd : 4'b0;
        // a redirect squashes whatever sits in D so it enters E as a bubble
        e_valid_d = d_valid_q & ~pc_redirect;
        e_op_d    = d_op_q;
        e_rd_d    = d_rd_q;
        m_valid_d = e_valid_q;
        m_rd_d    = e_rd_q;
        m_wr_d    = e_wr;
        st_d  = mult_start ? BUSY : (st_q == BUSY && cnt_q == 8'd0) ? DONE : st_q;
        cnt_d = mult_start ? CNT_INIT : (st_q == BUSY && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
        // redirect dominates: a refused offer during a redirect is a flush, not a stall
        stall_cnt_d = (in_valid & ~in_ready & ~pc_redirect & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (pc_redirect & ~&flush_cnt_q) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    // Pipeline shadows, multiplier state and event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_valid_q   <= 1'b0;
            e_valid_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            d_op_q      <= 4'b0;
            e_op_q      <= 4'b0;
            d_rd_q      <= 4'b0;
            e_rd_q      <= 4'b0;
            m_rd_q      <= 4'b0;
            m_wr_q      <= 1'b0;
            st_q        <= IDLE;
            cnt_q       <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            d_valid_q   <= d_valid_d;
            e_valid_q   <= e_valid_d;
            m_valid_q   <= m_valid_d;
            d_op_q      <= d_op_d;
            e_op_q      <= e_op_d;
            d_rd_q      <= d_rd_d;
            e_rd_q      <= e_rd_d;
            m_rd_q      <= m_rd_d;
            m_wr_q      <= m_wr_d;
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign d_valid   = d_valid_q;
    assign e_valid   = e_valid_q;
    assign m_valid   = m_valid_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for the pipeline hazard controller
module tb_pipe_hazard_ctrl;
    localparam int MULT_LAT = 4;
    localparam int CNT_W    = 8;
    localparam int RDY = 0, F1 = 1, F2 = 2, F3 = 3, DV = 4, EV = 5, MV = 6;
    localparam int RED = 7, MST = 8, MBSY = 9, SCNT = 10, FCNT = 11;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, ORR = 4'd2, JMP = 4'd11, BNQ = 4'd12, MFLO = 4'd13, MULT = 4'd15;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, br_taken;
    logic [3:0] in_codop, in_rs1, in_rs2, in_rd;
    logic [1:0] fwd1, fwd2, fwd3;
    logic d_valid, e_valid, m_valid, pc_redirect, mult_start, mult_busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct { string tag; int sig; int val; } exp_t;
    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    pipe_hazard_ctrl #(.MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_codop(in_codop), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .br_taken(br_taken), .fwd1(fwd1), .fwd2(fwd2), .fwd3(fwd3),
        .d_valid(d_valid), .e_valid(e_valid), .m_valid(m_valid),
        .pc_redirect(pc_redirect), .mult_start(mult_start), .mult_busy(mult_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int s);
        case (s)
            RDY:     return 32'(in_ready);
            F1:      return 32'(fwd1);
            F2:      return 32'(fwd2);
            F3:      return 32'(fwd3);
            DV:      return 32'(d_valid);
            EV:      return 32'(e_valid);
            MV:      return 32'(m_valid);
            RED:     return 32'(pc_redirect);
            MST:     return 32'(mult_start);
            MBSY:    return 32'(mult_busy);
            SCNT:    return 32'(stall_cnt);
            default: return 32'(flush_cnt);
        endcase
    endfunction

    task automatic want(input string tag, input int s, input int v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    // sample on the falling edge, then move to just after the next rising edge
    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.sig), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [3:0] op, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2);
        in_valid = v;
        in_codop = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        br_taken = 1'b0;
        offer(0, ADD, 0, 0, 0);
        #1;
        want("rst_rdy", RDY, 1); want("rst_dv", DV, 0); want("rst_ev", EV, 0); want("rst_mv", MV, 0);
        want("rst_red", RED, 0); want("rst_mst", MST, 0); want("rst_mbsy", MBSY, 0);
        want("rst_scnt", SCNT, 0); want("rst_fcnt", FCNT, 0); want("rst_fwd1", F1, 0);
        step();
        reset = 1'b1;
        // back-to-back RAW: one stall, then forward from E
        offer(1, ADD, 3, 1, 2); want("t1_add_rdy", RDY, 1); step();
        offer(1, SUB, 4, 3, 2); want("t1_raw", RDY, 0); want("t1_scnt0", SCNT, 0); step();
        want("t1_issue", RDY, 1); want("t1_fwd1", F1, 1); want("t1_fwd2", F2, 0);
        want("t1_scnt1", SCNT, 1); want("t1_ev", EV, 1); want("t1_dv", DV, 0); step();
        offer(0, ADD, 0, 0, 0); want("t1_dv2", DV, 1); want("t1_ev2", EV, 0); want("t1_mv2", MV, 1); step();
        // M-stage forwarding after idle gap; hazard with in_valid low is not counted
        offer(1, ADD, 5, 1, 2); want("t2_add_rdy", RDY, 1); step();
        offer(0, ORR, 6, 5, 5); want("t2_raw_idle", RDY, 0); step();
        want("t2_rdy", RDY, 1); want("t2_fwd1_e", F1, 1); want("t2_fwd2_e", F2, 1); want("t2_noidle", SCNT, 1); step();
        offer(1, ORR, 6, 5, 5); want("t2_or_rdy", RDY, 1); want("t2_fwd1_m", F1, 2); want("t2_fwd2_m", F2, 2);
        want("t2_fwd3", F3, 0); want("t2_scnt", SCNT, 1); step();
        offer(0, ORR, 6, 1, 2); want("t2_nohz", RDY, 1); step();
        offer(0, ADD, 6, 1, 2); want("t2_fwd3_e", F3, 1); step();
        want("t2_fwd3_m", F3, 2); step();
        // E has priority over M
        offer(1, ADD, 8, 1, 2); step();
        offer(1, ADD, 8, 1, 2); want("pri_rdy", RDY, 1); step();
        offer(0, SUB, 9, 8, 1); want("pri_raw", RDY, 0); step();
        want("pri_fwd1", F1, 1); want("pri_fwd2", F2, 0); step();
        // JMP squashes the following instruction
        offer(1, JMP, 0, 0, 0); want("t3_jmp_rdy", RDY, 1); step();
        offer(1, ADD, 9, 1, 2); want("t3_add_rdy", RDY, 1); want("t3_nored", RED, 0); step();
        offer(1, ADD, 10, 1, 2); want("t3_red", RED, 1); want("t3_rdy", RDY, 0); want("t3_dv", DV, 1);
        want("t3_ev", EV, 1); want("t3_fcnt0", FCNT, 0); want("t3_scnt", SCNT, 1); step();
        offer(0, ADD, 0, 0, 0); want("t3_red_off", RED, 0); want("t3_dv_bub", DV, 0); want("t3_squash", EV, 0);
        want("t3_mv", MV, 1); want("t3_fcnt1", FCNT, 1); want("t3_scnt_dom", SCNT, 1); step();
        // BNQ not taken, then taken
        offer(1, BNQ, 0, 0, 0); step();
        offer(0, ADD, 0, 0, 0); br_taken = 1'b1; want("t4_no_bnq", RED, 0); step();
        br_taken = 1'b0; want("t4_nt_red", RED, 0); want("t4_nt_rdy", RDY, 1); step();
        want("t4_nt_fcnt", FCNT, 1); step();
        offer(1, BNQ, 0, 0, 0); step();
        offer(0, ADD, 0, 0, 0); step();
        br_taken = 1'b1; offer(1, ADD, 1, 2, 3); want("t4_tk_red", RED, 1); want("t4_tk_rdy", RDY, 0); step();
        br_taken = 1'b0; offer(0, ADD, 0, 0, 0); want("t4_tk_fcnt", FCNT, 2); want("t4_tk_scnt", SCNT, 1);
        want("t4_tk_ev", EV, 0); step();
        // MULT followed by MFLO: held MULT_LAT+1 cycles
        offer(1, MULT, 0, 1, 2); want("t5_mult_rdy", RDY, 1); want("t5_idle_bsy", MBSY, 0); want("t5_idle_st", MST, 0); step();
        offer(1, MFLO, 11, 0, 0); want("t5_start", MST, 1); want("t5_bsy0", MBSY, 1); want("t5_hold0", RDY, 0); step();
        for (int i = 0; i < MULT_LAT; i++) begin
            want("t5_hold", RDY, 0); want("t5_bsy", MBSY, 1); want("t5_onepulse", MST, 0); step();
        end
        want("t5_issue", RDY, 1); want("t5_done_bsy", MBSY, 0); want("t5_scnt", SCNT, 1 + MULT_LAT + 1); step();
        offer(0, ADD, 0, 0, 0); want("t5_dv", DV, 1); want("t5_nostart", MST, 0); step();
        // stall counter saturation, then reset in the middle of BUSY
        offer(1, MULT, 0, 1, 2);
        for (int g = 0; g < 4000 && stall_cnt != '1; g++) step();
        want("t6_sat", SCNT, 255); step();
        for (int i = 0; i < 8; i++) begin
            want("t6_sat_hold", SCNT, 255); step();
        end
        for (int g = 0; g < 50 && !(mult_busy && !mult_start); g++) step();
        check("t6_pre_busy", 32'(mult_busy), 1);
        #2;
        reset = 1'b0;
        want("t6_dv", DV, 0); want("t6_ev", EV, 0); want("t6_mv", MV, 0); want("t6_scnt", SCNT, 0);
        want("t6_fcnt", FCNT, 0); want("t6_bsy", MBSY, 0); want("t6_rdy", RDY, 1); step();
        reset = 1'b1;
        offer(1, MFLO, 12, 0, 0); want("t6_mflo_rdy", RDY, 1); want("t6_mflo_bsy", MBSY, 0); step();
        offer(0, ADD, 0, 0, 0); want("t6_mflo_dv", DV, 1); want("t6_scnt_after", SCNT, 0); want("t6_nostart", MST, 0); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
